pipe_stage_skid: RTL

Parametrised elastic pipeline-stage register for the 8-bit pipelined processor; generalises the fixed stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries a control word plus NLANE data lanes of DATA_W bits under a valid/ready handshake. A two-entry skid buffer lets the upstream stage see a registered ready. It supports hazard flush with bubble insertion, so a stalled or flushed stage never presents stale write-enables downstream.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry.sv | 37 +++
 rtl/pipe_stage_skid.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
//   pipe_state_t          : stage occupancy state (EMPTY, ONE, TWO)
//   PIPE_CTRL_BUBBLE_DEF  : default bubble control word (all zeros, truncated to CTRL_W)
//   lane_lsb()            : lane k of a packed lane bus occupies bits [k*DATA_W +: DATA_W]
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [63:0] PIPE_CTRL_BUBBLE_DEF = '0;

    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: control word plus NLANE data lanes.
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-low reset
//   load        : capture d_ctrl/d_data on the next edge
//   clear       : load CLEAR_CTRL and zero lanes (wins over load)
//   d_ctrl/d_data : next contents
//   q_ctrl/q_data : held contents
module pipe_entry #(
    parameter int unsigned          CTRL_W     = 8,
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          NLANE      = 5,
    parameter logic [CTRL_W-1:0]    CLEAR_CTRL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      clear,
    input  logic [CTRL_W-1:0]         d_ctrl,
    input  logic [NLANE*DATA_W-1:0]   d_data,
    output logic [CTRL_W-1:0]         q_ctrl,
    output logic [NLANE*DATA_W-1:0]   q_data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_ctrl <= CLEAR_CTRL;
            q_data <= '0;
        end else if (clear) begin
            q_ctrl <= CLEAR_CTRL;
            q_data <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs the one word
// that may arrive while the downstream stalls, so in_ready can be a pure
// function of state.
// Ports:
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready depends on state only)
//   in_ctrl/in_data       : upstream control word and packed lanes
//   flush                 : drop all held entries and the same-cycle input
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : held word; CTRL_BUBBLE / zeros while out_valid=0
//   occupancy             : number of held entries (0..2)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned          CTRL_W      = 8,
    parameter int unsigned          DATA_W      = 8,
    parameter int unsigned          NLANE       = 5,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NLANE*DATA_W-1:0]   in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NLANE*DATA_W-1:0]   out_data,
    output logic [1:0]                occupancy
);

    pipe_state_t state, state_nxt;

    logic                    accept, pop;
    logic                    main_load, main_from_skid, skid_load;
    logic [CTRL_W-1:0]       main_ctrl, skid_ctrl, main_d_ctrl;
    logic [NLANE*DATA_W-1:0] main_data, skid_data, main_d_data;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides every transition, including a TWO-state pop.
        if (flush) begin
            state_nxt = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .NLANE      (NLANE),
        .CLEAR_CTRL (CTRL_BUBBLE)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (flush),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .NLANE      (NLANE),
        .CLEAR_CTRL (CTRL_BUBBLE)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (flush),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    // Stale contents never leak downstream: gate on out_valid.
    assign out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE;
    assign out_data = out_valid ? main_data : '0;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
